// File: rtl/knn_pkg.sv
// Shared types for the k-nearest-neighbour candidate feeder.
//   point_t        : packed 2-D point {x, y}
//   feeder_state_t : feeder FSM states
//   sat_sq_dist    : reference squared distance with saturation, used by the bench model
package knn_pkg;

    localparam int unsigned KnnCoordWidth = 16;
    localparam int unsigned KnnTagWidth   = 32;

    typedef struct packed {
        logic [KnnCoordWidth-1:0] x;
        logic [KnnCoordWidth-1:0] y;
    } point_t;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StSettle,
        StDecide,
        StEvict,
        StInsert,
        StDone
    } feeder_state_t;

    // Assumes KnnTagWidth == 2*KnnCoordWidth, so only the carry bit can overflow the tag.
    function automatic logic [KnnTagWidth-1:0] sat_sq_dist(input point_t q, input point_t p);
        logic [KnnCoordWidth-1:0]   dx;
        logic [KnnCoordWidth-1:0]   dy;
        logic [2*KnnCoordWidth-1:0] sx;
        logic [2*KnnCoordWidth-1:0] sy;
        logic [2*KnnCoordWidth:0]   s;
        dx = (q.x >= p.x) ? q.x - p.x : p.x - q.x;
        dy = (q.y >= p.y) ? q.y - p.y : p.y - q.y;
        sx = {{KnnCoordWidth{1'b0}}, dx} * {{KnnCoordWidth{1'b0}}, dx};
        sy = {{KnnCoordWidth{1'b0}}, dy} * {{KnnCoordWidth{1'b0}}, dy};
        s  = {1'b0, sx} + {1'b0, sy};
        return s[2*KnnCoordWidth] ? '1 : s[KnnTagWidth-1:0];
    endfunction

endpackage

// File: rtl/sq_dist_pipe.sv
// Two-stage squared-distance pipeline.
//   S1: |qx-px|, |qy-py|      S2: dx*dx + dy*dy, saturated to TAG_WIDTH
// Ports:
//   clk_in, rst_in  : clock, synchronous active-high reset
//   flush_in        : drop everything in flight
//   advance_in      : both stages shift by one this cycle
//   valid_in/point_in/last_in : point entering S1 (taken only when advance_in)
//   query_in        : query point {x, y}
//   valid_out/point_out/tag_out/last_out : S2 contents
module sq_dist_pipe
    import knn_pkg::*;
#(
    parameter int unsigned COORD_WIDTH = 16,
    parameter int unsigned TAG_WIDTH   = 32
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     flush_in,
    input  logic                     advance_in,
    input  logic                     valid_in,
    input  logic [2*COORD_WIDTH-1:0] point_in,
    input  logic                     last_in,
    input  logic [2*COORD_WIDTH-1:0] query_in,
    output logic                     valid_out,
    output logic [2*COORD_WIDTH-1:0] point_out,
    output logic [TAG_WIDTH-1:0]     tag_out,
    output logic                     last_out
);

    localparam int unsigned CW = COORD_WIDTH;
    localparam int unsigned PW = 2 * COORD_WIDTH;
    localparam int unsigned SW = 2 * COORD_WIDTH + 1;

    function automatic logic [CW-1:0] abs_diff(input logic [CW-1:0] a, input logic [CW-1:0] b);
        return (a >= b) ? a - b : b - a;
    endfunction

    logic          s1_valid_q;
    logic          s1_last_q;
    logic [PW-1:0] s1_point_q;
    logic [CW-1:0] s1_dx_q;
    logic [CW-1:0] s1_dy_q;

    logic [PW-1:0]        sq_x;
    logic [PW-1:0]        sq_y;
    logic [SW-1:0]        sum;
    logic [TAG_WIDTH-1:0] tag_sat;

    assign sq_x = {{CW{1'b0}}, s1_dx_q} * {{CW{1'b0}}, s1_dx_q};
    assign sq_y = {{CW{1'b0}}, s1_dy_q} * {{CW{1'b0}}, s1_dy_q};
    assign sum  = {1'b0, sq_x} + {1'b0, sq_y};

    if (TAG_WIDTH >= SW) begin : g_wide
        assign tag_sat = TAG_WIDTH'(sum);
    end else begin : g_sat
        assign tag_sat = (|sum[SW-1:TAG_WIDTH]) ? '1 : sum[TAG_WIDTH-1:0];
    end

    always_ff @(posedge clk_in) begin
        if (rst_in || flush_in) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_point_q <= '0;
            s1_dx_q    <= '0;
            s1_dy_q    <= '0;
            valid_out  <= 1'b0;
            last_out   <= 1'b0;
            point_out  <= '0;
            tag_out    <= '0;
        end else if (advance_in) begin
            s1_valid_q <= valid_in;
            s1_last_q  <= valid_in & last_in;
            s1_point_q <= point_in;
            s1_dx_q    <= abs_diff(query_in[PW-1:CW], point_in[PW-1:CW]);
            s1_dy_q    <= abs_diff(query_in[CW-1:0], point_in[CW-1:0]);
            valid_out  <= s1_valid_q;
            last_out   <= s1_last_q;
            point_out  <= s1_point_q;
            tag_out    <= tag_sat;
        end
    end

endmodule

// File: rtl/knn_candidate_feeder.sv
// Feeds the k-NN priority queue: computes squared distances of streamed points to a latched
// query and keeps the queue holding the closest points (evict-largest when strictly closer).
// Ports:
//   clk_in, rst_in                     : clock, synchronous active-high reset
//   start_in, query_in                 : begin (or abort and restart) a search with query_in
//   point_in/point_valid_in/point_last_in/point_ready_out : candidate point stream
//   q_flush_out, q_enq_out, q_enq_data_out, q_enq_tag_out, q_deq_largest_out : queue control
//   q_full_in, q_max_tag_in            : queue status
//   busy_out, done_out                 : search status; done_out pulses once per finished search
//   inserted_count_out, dropped_count_out : saturating per-search statistics
module knn_candidate_feeder
    import knn_pkg::*;
#(
    parameter int unsigned COORD_WIDTH   = 16,
    parameter int unsigned TAG_WIDTH     = 32,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned COUNT_WIDTH   = 16
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     start_in,
    input  logic [2*COORD_WIDTH-1:0] query_in,
    input  logic [2*COORD_WIDTH-1:0] point_in,
    input  logic                     point_valid_in,
    input  logic                     point_last_in,
    output logic                     point_ready_out,
    output logic                     q_flush_out,
    output logic                     q_enq_out,
    output logic [2*COORD_WIDTH-1:0] q_enq_data_out,
    output logic [TAG_WIDTH-1:0]     q_enq_tag_out,
    output logic                     q_deq_largest_out,
    input  logic                     q_full_in,
    input  logic [TAG_WIDTH-1:0]     q_max_tag_in,
    output logic                     busy_out,
    output logic                     done_out,
    output logic [COUNT_WIDTH-1:0]   inserted_count_out,
    output logic [COUNT_WIDTH-1:0]   dropped_count_out
);

    localparam int unsigned PW = 2 * COORD_WIDTH;
    localparam logic [7:0] SettleLast = 8'(SETTLE_CYCLES - 1);

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
        return (&v) ? v : v + COUNT_WIDTH'(1);
    endfunction

    logic [PW-1:0]        query_q;
    logic                 s2_valid;
    logic                 s2_last;
    logic [PW-1:0]        s2_point;
    logic [TAG_WIDTH-1:0] s2_tag;

    logic                 cand_valid_q;
    logic                 cand_last_q;
    logic [PW-1:0]        cand_point_q;
    logic [TAG_WIDTH-1:0] cand_tag_q;

    logic          last_seen_q;   // last point accepted; block further input
    logic          last_done_q;   // last point's candidate has been resolved
    feeder_state_t state_q;
    feeder_state_t ret_q;
    logic [7:0]    settle_cnt_q;

    logic advance;
    logic accept;
    logic cand_closer;
    logic cand_consume;

    assign cand_closer  = cand_tag_q < q_max_tag_in;
    assign cand_consume = (state_q == StInsert) ||
                          (state_q == StDecide && cand_valid_q && q_full_in && !cand_closer);
    assign advance      = !cand_valid_q || cand_consume || !s2_valid;
    // start_in gating keeps a point from being accepted in the cycle the pipeline is flushed.
    assign point_ready_out = busy_out && !last_seen_q && advance && !start_in;
    assign accept          = point_valid_in && point_ready_out;

    sq_dist_pipe #(
        .COORD_WIDTH (COORD_WIDTH),
        .TAG_WIDTH   (TAG_WIDTH)
    ) u_pipe (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .flush_in   (start_in),
        .advance_in (advance),
        .valid_in   (accept),
        .point_in   (point_in),
        .last_in    (point_last_in),
        .query_in   (query_q),
        .valid_out  (s2_valid),
        .point_out  (s2_point),
        .tag_out    (s2_tag),
        .last_out   (s2_last)
    );

    // Candidate register and search-progress flags.
    always_ff @(posedge clk_in) begin
        if (rst_in || start_in) begin
            cand_valid_q <= 1'b0;
            cand_last_q  <= 1'b0;
            cand_point_q <= '0;
            cand_tag_q   <= '0;
            last_seen_q  <= 1'b0;
            last_done_q  <= 1'b0;
        end else begin
            if (!cand_valid_q || cand_consume) begin
                cand_valid_q <= s2_valid;
                cand_last_q  <= s2_last;
                cand_point_q <= s2_point;
                cand_tag_q   <= s2_tag;
            end
            if (accept && point_last_in) begin
                last_seen_q <= 1'b1;
            end
            if (cand_consume && cand_last_q) begin
                last_done_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q            <= StIdle;
            ret_q              <= StIdle;
            settle_cnt_q       <= '0;
            query_q            <= '0;
            q_flush_out        <= 1'b0;
            q_enq_out          <= 1'b0;
            q_enq_data_out     <= '0;
            q_enq_tag_out      <= '0;
            q_deq_largest_out  <= 1'b0;
            busy_out           <= 1'b0;
            done_out           <= 1'b0;
            inserted_count_out <= '0;
            dropped_count_out  <= '0;
        end else if (start_in) begin
            // Also the abort path: any running search is discarded without done_out.
            state_q           <= StClear;
            query_q           <= query_in;
            q_flush_out       <= 1'b1;
            q_enq_out         <= 1'b0;
            q_deq_largest_out <= 1'b0;
            busy_out          <= 1'b1;
            done_out          <= 1'b0;
        end else begin
            q_flush_out       <= 1'b0;
            q_enq_out         <= 1'b0;
            q_deq_largest_out <= 1'b0;
            done_out          <= 1'b0;
            unique case (state_q)
                StIdle: ;
                StClear: begin
                    inserted_count_out <= '0;
                    dropped_count_out  <= '0;
                    settle_cnt_q       <= '0;
                    ret_q              <= StDecide;
                    state_q            <= StSettle;
                end
                StSettle: begin
                    if (settle_cnt_q == SettleLast) begin
                        state_q <= ret_q;
                        if (ret_q == StInsert) begin
                            q_enq_out      <= 1'b1;
                            q_enq_data_out <= cand_point_q;
                            q_enq_tag_out  <= cand_tag_q;
                        end
                    end else begin
                        settle_cnt_q <= settle_cnt_q + 8'd1;
                    end
                end
                StDecide: begin
                    if (cand_valid_q) begin
                        if (!q_full_in) begin
                            state_q        <= StInsert;
                            q_enq_out      <= 1'b1;
                            q_enq_data_out <= cand_point_q;
                            q_enq_tag_out  <= cand_tag_q;
                        end else if (cand_closer) begin
                            state_q           <= StEvict;
                            q_deq_largest_out <= 1'b1;
                        end else begin
                            dropped_count_out <= sat_inc(dropped_count_out);
                        end
                    end else if (last_done_q) begin
                        state_q  <= StDone;
                        done_out <= 1'b1;
                        busy_out <= 1'b0;
                    end
                end
                StEvict: begin
                    settle_cnt_q <= '0;
                    ret_q        <= StInsert;
                    state_q      <= StSettle;
                end
                StInsert: begin
                    inserted_count_out <= sat_inc(inserted_count_out);
                    settle_cnt_q       <= '0;
                    ret_q              <= StDecide;
                    state_q            <= StSettle;
                end
                StDone: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
